// File: rtl/rnn_mem_responder.sv
// Backing store and start handshake for the RNN accelerator: weight/bias/cfg banks,
// output capture bank, input-vector stream, and host load/readback.
module rnn_mem_responder #(
    parameter int OUT_AW = 12,
    parameter int X_AW   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              err,
    output logic [16:0]       wr_count,
    output logic              ready,
    input  logic              busy,
    input  logic              i_en,
    output logic [31:0]       idata,
    input  logic              mce,
    input  logic [2:0]        msel,
    input  logic [16:0]       maddr,
    input  logic [19:0]       mdata_w,
    output logic [19:0]       mdata_r,
    input  logic              ld_en,
    input  logic [2:0]        ld_sel,
    input  logic [16:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [OUT_AW-1:0] rd_addr,
    output logic [19:0]       rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

    state_t state, state_nx;

    logic [19:0] w_ih    [0:2047];
    logic [19:0] b_ih    [0:63];
    logic [19:0] w_hh    [0:4095];
    logic [19:0] b_hh    [0:63];
    logic [19:0] out_mem [0:(2**OUT_AW)-1];
    logic [31:0] vec     [0:(2**X_AW)-1];
    logic [19:0] cfg_steps;

    logic [X_AW:0] xptr;
    logic [19:0]   rd_word;
    logic          acc_bad, acc_ok, out_wr, ld_ok, ld_err, arm_entry;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ARM;
            S_ARM:   if (busy) state_nx = S_RUN;
            S_RUN:   if (!busy) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bank decode: out-of-range or unmapped selects are flagged and leave all state untouched.
    always_comb begin
        acc_bad = 1'b0;
        rd_word = '0;
        case (msel)
            3'd0: begin acc_bad = |maddr[16:11]; rd_word = w_ih[maddr[10:0]]; end
            3'd1: begin acc_bad = |maddr[16:6];  rd_word = b_ih[maddr[5:0]];  end
            3'd2: begin acc_bad = |maddr[16:12]; rd_word = w_hh[maddr[11:0]]; end
            3'd3: begin acc_bad = |maddr[16:6];  rd_word = b_hh[maddr[5:0]];  end
            3'd4: rd_word = (maddr == 17'd0) ? cfg_steps : 20'd0;
            3'd5: begin
                acc_bad = (maddr >> OUT_AW) != 17'd0;
                rd_word = out_mem[maddr[OUT_AW-1:0]];
            end
            default: acc_bad = 1'b1;
        endcase
    end

    assign acc_ok    = mce && !acc_bad;
    assign out_wr    = acc_ok && (msel == 3'd5);
    assign ld_ok     = ld_en && (state == S_IDLE) && (ld_sel != 3'd7);
    assign ld_err    = ld_en && ((state != S_IDLE) || (ld_sel == 3'd7));
    assign arm_entry = (state == S_IDLE) && start;
    assign ready     = (state == S_ARM);
    assign rd_data   = out_mem[rd_addr];

    // Storage is deliberately outside reset so loaded banks survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            case (ld_sel)
                3'd0: w_ih[ld_addr[10:0]] <= ld_data[19:0];
                3'd1: b_ih[ld_addr[5:0]]  <= ld_data[19:0];
                3'd2: w_hh[ld_addr[11:0]] <= ld_data[19:0];
                3'd3: b_hh[ld_addr[5:0]]  <= ld_data[19:0];
                3'd4: if (ld_addr == 17'd0) cfg_steps <= ld_data[19:0];
                3'd5: out_mem[ld_addr[OUT_AW-1:0]] <= ld_data[19:0];
                3'd6: vec[ld_addr[X_AW-1:0]] <= ld_data;
                default: ;
            endcase
        end
        if (out_wr) out_mem[maddr[OUT_AW-1:0]] <= mdata_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_count <= '0;
            idata    <= '0;
            mdata_r  <= '0;
            xptr     <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == S_RUN) && !busy;
            if ((mce && acc_bad) || ld_err) err <= 1'b1;
            if (acc_ok) mdata_r <= rd_word;
            if (arm_entry) begin
                wr_count <= '0;
                xptr     <= '0;
                idata    <= '0;
            end else begin
                if (out_wr && (wr_count != '1)) wr_count <= wr_count + 17'd1;
                // Past the last vector the core's overfetch just reads zeros.
                if (i_en) begin
                    if (!xptr[X_AW]) begin
                        idata <= vec[xptr[X_AW-1:0]];
                        xptr  <= xptr + 1'b1;
                    end else begin
                        idata <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Randomized self-checking bench for rnn_mem_responder against a bank-level reference model.
module tb_rnn_mem_responder;
    localparam int OUT_AW = 12;
    localparam int X_AW   = 1;

    logic clk = 1'b0;
    logic reset, start, busy, i_en, mce, ld_en;
    logic [2:0] msel, ld_sel;
    logic [16:0] maddr, ld_addr;
    logic [19:0] mdata_w;
    logic [31:0] ld_data;
    logic [OUT_AW-1:0] rd_addr;
    logic done, err, ready;
    logic [16:0] wr_count;
    logic [31:0] idata;
    logic [19:0] mdata_r, rd_data;

    int errors = 0;
    int checks = 0;

    logic [19:0] m_wih [2048];
    logic [19:0] m_bih [64];
    logic [19:0] m_whh [4096];
    logic [19:0] m_bhh [64];
    logic [19:0] m_out [4096];
    logic [31:0] m_vec [2];
    logic [19:0] m_cfg, m_mdr;
    logic [16:0] m_wr;
    logic [31:0] m_idata;
    int m_xptr;
    logic m_err;

    rnn_mem_responder #(.OUT_AW(OUT_AW), .X_AW(X_AW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .err(err),
        .wr_count(wr_count), .ready(ready), .busy(busy), .i_en(i_en), .idata(idata),
        .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic bit m_ok(input int s, input int a);
        case (s)
            0: return a < 2048;
            1, 3: return a < 64;
            2: return a < 4096;
            4: return 1'b1;
            5: return a < (1 << OUT_AW);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [19:0] m_read(input int s, input int a);
        case (s)
            0: return m_wih[a];
            1: return m_bih[a];
            2: return m_whh[a];
            3: return m_bhh[a];
            4: return (a == 0) ? m_cfg : 20'd0;
            default: return m_out[a];
        endcase
    endfunction

    // Host load performed in IDLE; the model mirrors the accepted write.
    task automatic load(input int s, input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_sel = s[2:0]; ld_addr = a[16:0]; ld_data = d;
        tick();
        ld_en = 1'b0;
        case (s)
            0: m_wih[a] = d[19:0];
            1: m_bih[a] = d[19:0];
            2: m_whh[a] = d[19:0];
            3: m_bhh[a] = d[19:0];
            4: if (a == 0) m_cfg = d[19:0];
            5: m_out[a] = d[19:0];
            6: m_vec[a] = d;
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic access(input int s, input int a, input logic [19:0] w);
        mce = 1'b1; msel = s[2:0]; maddr = a[16:0]; mdata_w = w;
        tick();
        mce = 1'b0;
        if (m_ok(s, a)) begin
            m_mdr = m_read(s, a);
            if (s == 5) begin
                m_out[a] = w;
                if (m_wr != 17'h1ffff) m_wr++;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic go_arm();
        start = 1'b1; tick(); start = 1'b0;
        m_wr = '0; m_xptr = 0; m_idata = '0;
    endtask

    task automatic go_run();
        go_arm();
        busy = 1'b1; tick();
    endtask

    task automatic end_run();
        busy = 1'b0; tick(); tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        m_err = 1'b0; m_wr = '0; m_mdr = '0; m_xptr = 0; m_idata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (wr_count !== 17'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
        checks++; if (idata !== 32'd0 || mdata_r !== 20'd0) begin
            errors++; $display("FAIL reset_data: got idata=%h mdata_r=%h want 0/0", idata, mdata_r); end
    endtask

    task automatic test_mem_read();
        int qs[$];
        int qa[$];
        for (int i = 0; i < 12; i++) begin
            int ss;
            int aa;
            ss = $urandom_range(0, 3);
            aa = (ss == 0) ? $urandom_range(0, 2047) : (ss == 2) ? $urandom_range(0, 4095) : $urandom_range(0, 63);
            load(ss, aa, $urandom);
            qs.push_back(ss); qa.push_back(aa);
        end
        load(2, 5 * 64 + 7, 32'h000ABCD);
        load(0, 100, $urandom);
        load(4, 0, 32'd3);
        for (int i = 0; i < qs.size(); i++) begin
            access(qs[i], qa[i], 20'd0);
            checks++; if (mdata_r !== m_mdr) begin
                errors++; $display("FAIL rand_read bank%0d[%0d]: got %h want %h", qs[i], qa[i], mdata_r, m_mdr); end
        end
        access(2, 5 * 64 + 7, 20'd0);
        checks++; if (mdata_r !== 20'h0ABCD) begin errors++; $display("FAIL whh_read: got %h want 0abcd", mdata_r); end
        tick();
        checks++; if (mdata_r !== 20'h0ABCD) begin errors++; $display("FAIL whh_hold: got %h want 0abcd", mdata_r); end
        access(4, 0, 20'd0);
        checks++; if (mdata_r !== 20'd3) begin errors++; $display("FAIL cfg_read: got %h want 3", mdata_r); end
        access(4, 5, 20'd0);
        checks++; if (mdata_r !== 20'd0) begin errors++; $display("FAIL cfg_other: got %h want 0", mdata_r); end
    endtask

    task automatic test_handshake();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_idle_ready: got %b want 0", ready); end
        go_arm();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ready !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL hs_arm%0d: got ready=%b done=%b want 1/0", i, ready, done); end
            if (i < 2) tick();
        end
        busy = 1'b1; tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_run_ready: got %b want 0", ready); end
        tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hs_run_done: got %b want 0", done); end
        busy = 1'b0; tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hs_done_pulse: got %b want 1", done); end
        tick();
        checks++; if (done !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL hs_after: got done=%b ready=%b want 0/0", done, ready); end
    endtask

    task automatic test_stream();
        load(6, 0, 32'hDEADBEEF);
        load(6, 1, 32'h00000001);
        go_arm();
        for (int i = 0; i < 10; i++) begin
            i_en = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            if (i_en) begin
                m_idata = (m_xptr < 2) ? m_vec[m_xptr] : 32'd0;
                if (m_xptr < 2) m_xptr++;
            end
            checks++; if (idata !== m_idata) begin
                errors++; $display("FAIL stream%0d: got %h want %h", i, idata, m_idata); end
        end
        i_en = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err: got %b want 0", err); end
        busy = 1'b1; tick();
        end_run();
    endtask

    task automatic test_out_write();
        for (int i = 0; i < 64; i++) load(5, i, $urandom);
        load(5, 137, 32'h12345);
        go_run();
        rd_addr = 12'd137;
        mce = 1'b1; msel = 3'd5; maddr = 17'd137; mdata_w = 20'hF0000;
        #1;
        checks++; if (rd_data !== 20'h12345) begin errors++; $display("FAIL rd_before_edge: got %h want 12345", rd_data); end
        access(5, 137, 20'hF0000);
        checks++; if (rd_data !== 20'hF0000 || mdata_r !== 20'h12345) begin
            errors++; $display("FAIL out_write: got rd=%h old=%h want f0000/12345", rd_data, mdata_r); end
        checks++; if (wr_count !== 17'd1) begin errors++; $display("FAIL wr_count1: got %0d want 1", wr_count); end
        for (int i = 0; i < 6; i++) begin
            int a;
            a = $urandom_range(0, 63);
            access(5, a, 20'($urandom));
            rd_addr = a[OUT_AW-1:0]; #1;
            checks++; if (rd_data !== m_out[a] || mdata_r !== m_mdr) begin
                errors++; $display("FAIL rand_write[%0d]: got rd=%h old=%h want %h/%h", a, rd_data, mdata_r, m_out[a], m_mdr); end
        end
        checks++; if (wr_count !== m_wr) begin errors++; $display("FAIL wr_count: got %0d want %0d", wr_count, m_wr); end
        end_run();
        go_arm();
        checks++; if (wr_count !== 17'd0) begin errors++; $display("FAIL wr_count_clear: got %0d want 0", wr_count); end
        busy = 1'b1; tick();
        end_run();
    endtask

    task automatic test_reset_midrun();
        go_run();
        i_en = 1'b1; tick(); i_en = 1'b0;
        checks++; if (idata !== m_vec[0]) begin errors++; $display("FAIL mid_idata: got %h want %h", idata, m_vec[0]); end
        for (int i = 0; i < 5; i++) access(5, i, 20'($urandom));
        checks++; if (wr_count !== 17'd5) begin errors++; $display("FAIL mid_wr5: got %0d want 5", wr_count); end
        do_reset();
        checks++; if (ready !== 1'b0 || done !== 1'b0 || wr_count !== 17'd0 || idata !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got ready=%b done=%b wr=%0d idata=%h want 0", ready, done, wr_count, idata); end
        busy = 1'b0; tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", done); end
        access(0, 100, 20'd0);
        checks++; if (mdata_r !== m_wih[100]) begin errors++; $display("FAIL wih_survives: got %h want %h", mdata_r, m_wih[100]); end
    endtask

    task automatic test_errors();
        load(1, 5, $urandom);
        access(1, 5, 20'd0);
        access(1, 64, 20'd0);
        checks++; if (err !== m_err || err !== 1'b1) begin errors++; $display("FAIL err_range: got %b want 1", err); end
        checks++; if (mdata_r !== m_mdr) begin errors++; $display("FAIL err_hold: got %h want %h", mdata_r, m_mdr); end
        go_run();
        ld_en = 1'b1; ld_sel = 3'd1; ld_addr = 17'd5; ld_data = ~{12'd0, m_bih[5]}; tick(); ld_en = 1'b0;
        end_run();
        access(1, 5, 20'd0);
        checks++; if (mdata_r !== m_bih[5] || err !== 1'b1) begin
            errors++; $display("FAIL ld_in_run: got %h err=%b want %h/1", mdata_r, err, m_bih[5]); end
        do_reset();
        access(7, 0, 20'd0);
        checks++; if (err !== m_err) begin errors++; $display("FAIL err_msel7: got %b want %b", err, m_err); end
        do_reset();
        access(5, (1 << OUT_AW) | 9, 20'hAAAAA);
        rd_addr = 12'd9; #1;
        checks++; if (err !== m_err || rd_data !== m_out[9] || wr_count !== 17'd0) begin
            errors++; $display("FAIL err_out_high: got err=%b rd=%h wr=%0d want %b/%h/0", err, rd_data, wr_count, m_err, m_out[9]); end
        do_reset();
        load(7, 0, 32'd1);
        checks++; if (err !== m_err) begin errors++; $display("FAIL err_ldsel7: got %b want %b", err, m_err); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; busy = 1'b0; i_en = 1'b0; mce = 1'b0; ld_en = 1'b0;
        msel = '0; ld_sel = '0; maddr = '0; ld_addr = '0; mdata_w = '0; ld_data = '0; rd_addr = '0;
        m_err = 1'b0;
        tick();
        test_reset();
        test_mem_read();
        test_handshake();
        test_stream();
        test_out_write();
        test_reset_midrun();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
